// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   N-channel arbiter and strobe sequencer for a single asynchronous external
//   SRAM. Requests are granted round-robin or by fixed priority. Each access
//   runs SETUP -> ACCESS (ACCESS_CYCLES) -> HOLD. The granted channel gets a
//   one-cycle acknowledge in the HOLD cycle.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   reqValid    per-channel request
//   reqWrite    per-channel direction, 1 = write
//   reqAddr     packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   reqData     packed write data, channel i at [i*DATA_W +: DATA_W]
//   reqAck      one-hot, one-cycle completion pulse
//   rspData     read data, valid in the ack cycle, held until the next read
//   busy        high while a transaction is in flight
//   memDataBus  SRAM data, driven only during write transactions
//   memAddrBus  SRAM address
//   memRead     OE, active low
//   memWrite    WE, active low
//   memEnable   CE, active low
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int CHANNELS      = 2,
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        reqValid,
  input  logic [CHANNELS-1:0]        reqWrite,
  input  logic [CHANNELS*ADDR_W-1:0] reqAddr,
  input  logic [CHANNELS*DATA_W-1:0] reqData,
  output logic [CHANNELS-1:0]        reqAck,
  output logic [DATA_W-1:0]          rspData,
  output logic                       busy,
  inout  wire  [DATA_W-1:0]          memDataBus,
  output logic [ADDR_W-1:0]          memAddrBus,
  output logic                       memRead,
  output logic                       memWrite,
  output logic                       memEnable
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} stateType;

  stateType           state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   grantNext;
  logic               anyReq;
  logic               latWrite;
  logic [DATA_W-1:0]  latData;
  logic               driveEn;
  logic               found;
  int                 idx;

  // Arbitration: pick the winning channel from the live request vector.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    grantNext = last;
    found     = 1'b0;
    idx       = 0;
    anyReq    = |reqValid;
    if (PRIORITY_MODE != 0) begin
      // Descending scan so the lowest requesting index is written last.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (reqValid[IDX_W'(i)]) grantNext = IDX_W'(i);
      end
    end else begin
      // Search starts one past the previous winner and wraps around.
      for (int k = 1; k <= CHANNELS; k++) begin
        idx = (int'(last) + k) % CHANNELS;
        if (!found && reqValid[IDX_W'(idx)]) begin
          grantNext = IDX_W'(idx);
          found     = 1'b1;
        end
      end
    end
  end

  // Write data is only ever driven by the latched copy, never by reqData.
  assign memDataBus = driveEn ? latData : {DATA_W{1'bz}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= '0;
      last       <= LAST_RESET;
      latWrite   <= 1'b0;
      latData    <= '0;
      driveEn    <= 1'b0;
      reqAck     <= '0;
      rspData    <= '0;
      busy       <= 1'b0;
      memAddrBus <= '0;
      memRead    <= 1'b1;
      memWrite   <= 1'b1;
      memEnable  <= 1'b1;
    end else begin
      reqAck <= '0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grant      <= grantNext;
            last       <= grantNext;
            latWrite   <= reqWrite[grantNext];
            latData    <= reqData[int'(grantNext)*DATA_W +: DATA_W];
            memAddrBus <= reqAddr[int'(grantNext)*ADDR_W +: ADDR_W];
            memEnable  <= 1'b0;
            memRead    <= reqWrite[grantNext];
            driveEn    <= reqWrite[grantNext];
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          memWrite <= ~latWrite;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            memWrite      <= 1'b1;
            memRead       <= 1'b1;
            if (!latWrite) rspData <= memDataBus;
            reqAck[grant] <= 1'b1;
            state         <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          // Address and data stay put through HOLD, then CE and the bus drop.
          memEnable <= 1'b1;
          driveEn   <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. Four instances share one request
//   stimulus: round-robin (main), fixed priority, ACCESS_CYCLES=1 and =4.
//   The main instance is connected to a small SRAM model.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int CH = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int AC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [CH-1:0]    reqValid;
  logic [CH-1:0]    reqWrite;
  logic [CH*AW-1:0] reqAddr;
  logic [CH*DW-1:0] reqData;

  logic [CH-1:0] ack;
  logic [DW-1:0] rsp;
  logic          busy;
  wire  [DW-1:0] bus;
  logic [AW-1:0] addr;
  logic          rd, wr, en;

  logic [CH-1:0] fpAck, a1Ack, a4Ack;
  logic [DW-1:0] fpRsp, a1Rsp, a4Rsp;
  logic          fpBusy, a1Busy, a4Busy;
  wire  [DW-1:0] fpBus, a1Bus, a4Bus;
  logic [AW-1:0] fpAddr, a1Addr, a4Addr;
  logic          fpRd, fpWr, fpEn, a1Rd, a1Wr, a1En, a4Rd, a4Wr, a4En;

  always #5 clk = ~clk;

  sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqData(reqData), .reqAck(ack), .rspData(rsp), .busy(busy), .memDataBus(bus),
    .memAddrBus(addr), .memRead(rd), .memWrite(wr), .memEnable(en));

  sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .PRIORITY_MODE(1)) dutFp (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqData(reqData), .reqAck(fpAck), .rspData(fpRsp), .busy(fpBusy), .memDataBus(fpBus),
    .memAddrBus(fpAddr), .memRead(fpRd), .memWrite(fpWr), .memEnable(fpEn));

  sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1), .PRIORITY_MODE(0)) dutA1 (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqData(reqData), .reqAck(a1Ack), .rspData(a1Rsp), .busy(a1Busy), .memDataBus(a1Bus),
    .memAddrBus(a1Addr), .memRead(a1Rd), .memWrite(a1Wr), .memEnable(a1En));

  sram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(4), .PRIORITY_MODE(0)) dutA4 (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqData(reqData), .reqAck(a4Ack), .rspData(a4Rsp), .busy(a4Busy), .memDataBus(a4Bus),
    .memAddrBus(a4Addr), .memRead(a4Rd), .memWrite(a4Wr), .memEnable(a4En));

  // SRAM model on the main instance: 16 words, low address bits only.
  logic [DW-1:0] sram [16];
  logic          sramLoaded = 1'b0;
  assign bus = (!en && !rd) ? sram[addr[3:0]] : {DW{1'bz}};
  always @(posedge clk) begin
    if (!rst && !sramLoaded) begin
      for (int i = 0; i < 16; i++) sram[i] <= 16'h1000 + 16'(i);
      sramLoaded <= 1'b1;
    end else if (!en && !wr) begin
      sram[addr[3:0]] <= bus;
    end
  end

  // Expected memory contents, updated only when a write is acknowledged.
  logic [DW-1:0] modelMem [16];

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    reqValid = '0;
    reqWrite = '0;
    reqAddr  = '0;
    reqData  = '0;
  endtask

  // Leaves the bench one time unit after an edge with reset released: cycle 0.
  task automatic doReset();
    idleInputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic setReq(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[c]          = 1'b1;
    reqWrite[c]          = w;
    reqAddr[c*AW +: AW]  = a;
    reqData[c*DW +: DW]  = d;
  endtask

  typedef struct {
    int            ch;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            expAck;   // cycle of the ack pulse
    logic [15:0]   expWe;    // cycles with WE low
    logic [15:0]   expRe;    // cycles with OE low
    logic [15:0]   expCe;    // cycles with CE low
    logic [DW-1:0] expRsp;   // read data in the ack cycle
  } vecType;

  // One isolated transaction on the main instance, cycle 0 = now.
  task automatic doSingle(input string tag, input vecType v);
    int          ackCyc = -1;
    int          nAck   = 0;
    logic [CH-1:0] ackV = '0;
    logic [DW-1:0] rspV = '0;
    logic [15:0] weM = '0, reM = '0, ceM = '0;
    logic        addrOk = 1'b1, dataOk = 1'b1;
    setReq(v.ch, v.wr, v.addr, v.data);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      if (!wr) weM[cyc] = 1'b1;
      if (!rd) reM[cyc] = 1'b1;
      if (!en) begin
        ceM[cyc] = 1'b1;
        if (addr !== v.addr) addrOk = 1'b0;
        if (v.wr && bus !== v.data) dataOk = 1'b0;
      end
      if (ack != '0) begin
        nAck++;
        if (ackCyc < 0) begin
          ackCyc = cyc;
          ackV   = ack;
          rspV   = rsp;
        end
        reqValid[v.ch] = 1'b0;
      end
    end
    reqValid[v.ch] = 1'b0;
    check({tag, " ack cycle"}, 32'(ackCyc), 32'(v.expAck));
    check({tag, " ack vector"}, 32'(ackV), 32'(1 << v.ch));
    check({tag, " ack count"}, 32'(nAck), 32'd1);
    check({tag, " WE cycles"}, 32'(weM), 32'(v.expWe));
    check({tag, " OE cycles"}, 32'(reM), 32'(v.expRe));
    check({tag, " CE cycles"}, 32'(ceM), 32'(v.expCe));
    check({tag, " address stable"}, 32'(addrOk), 32'd1);
    check({tag, " write data stable"}, 32'(dataOk), 32'd1);
    if (v.wr) modelMem[v.addr[3:0]] = v.data;
    else      check({tag, " read data"}, 32'(rspV), 32'(v.expRsp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecType vecs[7];
    vecType rb;
    int     rrCh[$];
    int     rrCyc[$];
    logic [DW-1:0] rrRsp[$];
    int     fpCount, fpOther;
    int     firstMain, firstA1, firstA4;
    logic   sawAck, sawBusy;
    // random-test reference state
    logic          active [CH];
    logic          aWr    [CH];
    logic [AW-1:0] aAddr  [CH];
    logic [DW-1:0] aData  [CH];
    int lastG, nextFree, grantAt, ackAt, gCh;
    logic [CH-1:0] expAck;

    for (int i = 0; i < 16; i++) modelMem[i] = 16'h1000 + 16'(i);
    idleInputs();

    //                ch wr addr      data      ack  WE       OE       CE       rsp
    vecs[0] = '{0, 1'b1, 18'h00005, 16'h1234, 4, 16'h000C, 16'h0000, 16'h001E, 16'h0000};
    vecs[1] = '{0, 1'b0, 18'h00005, 16'h0000, 4, 16'h0000, 16'h000E, 16'h001E, 16'h1234};
    vecs[2] = '{2, 1'b1, 18'h00009, 16'hBEEF, 4, 16'h000C, 16'h0000, 16'h001E, 16'h0000};
    vecs[3] = '{1, 1'b0, 18'h00009, 16'h0000, 4, 16'h0000, 16'h000E, 16'h001E, 16'hBEEF};
    vecs[4] = '{1, 1'b0, 18'h00003, 16'h0000, 4, 16'h0000, 16'h000E, 16'h001E, 16'h1003};
    vecs[5] = '{2, 1'b1, 18'h00003, 16'h0F0F, 4, 16'h000C, 16'h0000, 16'h001E, 16'h0000};
    vecs[6] = '{0, 1'b0, 18'h00003, 16'h0000, 4, 16'h0000, 16'h000E, 16'h001E, 16'h0F0F};

    // Reset state
    doReset();
    check("reset memEnable", 32'(en), 32'd1);
    check("reset memRead", 32'(rd), 32'd1);
    check("reset memWrite", 32'(wr), 32'd1);
    check("reset memAddrBus", 32'(addr), 32'd0);
    check("reset reqAck", 32'(ack), 32'd0);
    check("reset rspData", 32'(rsp), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) doSingle($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset in the middle of a write ACCESS
    doReset();
    setReq(0, 1'b1, 18'h00006, 16'h7777);
    step();
    step();
    check("pre-reset WE low", 32'(wr), 32'd0);
    #3 rst = 1'b0;
    #1;
    check("async reset memWrite", 32'(wr), 32'd1);
    check("async reset memRead", 32'(rd), 32'd1);
    check("async reset memEnable", 32'(en), 32'd1);
    check("async reset busy", 32'(busy), 32'd0);
    reqValid = '0;
    step();
    step();
    rst = 1'b1;
    sawAck  = 1'b0;
    sawBusy = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      if (ack != '0) sawAck = 1'b1;
      if (busy) sawBusy = 1'b1;
    end
    check("aborted access ack", 32'(sawAck), 32'd0);
    check("aborted access busy", 32'(sawBusy), 32'd0);

    // Round-robin vs fixed priority, all channels requesting reads
    doReset();
    for (int c = 0; c < CH; c++) setReq(c, 1'b0, AW'(c + 1), 16'h0000);
    fpCount = 0;
    fpOther = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      step();
      if (ack != '0) begin
        rrCh.push_back($clog2(ack));
        rrCyc.push_back(cyc);
        rrRsp.push_back(rsp);
      end
      if (fpAck != '0) begin
        fpCount++;
        if (fpAck != 3'b001) fpOther++;
      end
    end
    idleInputs();
    check("rr ack count", 32'(rrCh.size()), 32'd6);
    for (int i = 0; i < rrCh.size() && i < 6; i++) begin
      check($sformatf("rr grant %0d", i), 32'(rrCh[i]), 32'(i % 3));
      check($sformatf("rr ack cycle %0d", i), 32'(rrCyc[i]), 32'(4 + 5 * i));
      check($sformatf("rr read data %0d", i), 32'(rrRsp[i]), 32'(modelMem[(i % 3) + 1]));
    end
    check("fp ack count", 32'(fpCount), 32'd6);
    check("fp non-ch0 acks", 32'(fpOther), 32'd0);

    // Early drop: ch1 releases its request and scrambles its fields mid-ACCESS
    doReset();
    setReq(1, 1'b1, 18'h00007, 16'hCAFE);
    step();
    step();
    reqValid[1]      = 1'b0;
    reqWrite[1]      = 1'b0;
    reqAddr[AW +: AW] = 18'h3FFFF;
    reqData[DW +: DW] = 16'h0000;
    firstMain = -1;
    for (int cyc = 3; cyc <= 6; cyc++) begin
      step();
      if (cyc <= 4) begin
        check($sformatf("drop addr cycle %0d", cyc), 32'(addr), 32'h00007);
        check($sformatf("drop data cycle %0d", cyc), 32'(bus), 32'hCAFE);
      end
      if (ack != '0 && firstMain < 0) begin
        firstMain = cyc;
        check("drop ack vector", 32'(ack), 32'b010);
      end
    end
    check("drop ack cycle", 32'(firstMain), 32'd4);
    check("drop busy after", 32'(busy), 32'd0);
    modelMem[7] = 16'hCAFE;
    idleInputs();
    rb = '{0, 1'b0, 18'h00007, 16'h0000, 4, 16'h0000, 16'h000E, 16'h001E, 16'hCAFE};
    doSingle("drop readback", rb);

    // ACCESS_CYCLES sweep latency
    doReset();
    setReq(0, 1'b0, 18'h00002, 16'h0000);
    firstMain = -1;
    firstA1   = -1;
    firstA4   = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      if (ack   != '0 && firstMain < 0) firstMain = cyc;
      if (a1Ack != '0 && firstA1   < 0) firstA1   = cyc;
      if (a4Ack != '0 && firstA4   < 0) firstA4   = cyc;
    end
    idleInputs();
    check("sweep AC=1 ack cycle", 32'(firstA1), 32'd3);
    check("sweep AC=2 ack cycle", 32'(firstMain), 32'd4);
    check("sweep AC=4 ack cycle", 32'(firstA4), 32'd6);

    // Randomized traffic against a transaction-level reference
    doReset();
    for (int c = 0; c < CH; c++) active[c] = 1'b0;
    lastG    = CH - 1;
    nextFree = 0;
    grantAt  = -100;
    ackAt    = -1;
    gCh      = 0;
    for (int t = 0; t <= 600; t++) begin
      if (t > 0) begin
        step();
        expAck = (t == ackAt) ? CH'(1 << gCh) : '0;
        check("random ack", 32'(ack), 32'(expAck));
        check("random busy", 32'(busy), 32'(t > grantAt && t <= ackAt));
        if (t == ackAt) begin
          if (aWr[gCh]) modelMem[aAddr[gCh][3:0]] = aData[gCh];
          else check("random read data", 32'(rsp), 32'(modelMem[aAddr[gCh][3:0]]));
          active[gCh] = 1'b0;
        end
      end
      // Requesters: idle channels may raise a new request with fresh fields.
      for (int c = 0; c < CH; c++) begin
        if (!active[c] && ($urandom % 2 == 0)) begin
          active[c] = 1'b1;
          aWr[c]    = 1'($urandom % 2);
          aAddr[c]  = AW'($urandom_range(0, 15));
          aData[c]  = DW'($urandom);
        end
        if (active[c]) setReq(c, aWr[c], aAddr[c], aData[c]);
        else begin
          reqValid[c]         = 1'b0;
          reqAddr[c*AW +: AW] = AW'($urandom);
        end
      end
      // Arbiter accepts a new request once the previous access has finished.
      if (t >= nextFree) begin
        for (int k = 1; k <= CH; k++) begin
          if (t >= nextFree && active[(lastG + k) % CH]) begin
            gCh      = (lastG + k) % CH;
            lastG    = gCh;
            grantAt  = t;
            ackAt    = t + AC + 2;
            nextFree = t + AC + 3;
          end
        end
      end
    end
    idleInputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
